prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 Parameter WIDTH, default 32: COUNT, LIMIT, LOAD_VAL and CAP_VAL width in bits, legal range 2..32.
REQ-002 Parameter PRE_W, default 16: prescaler divisor width in bits, legal range 1..32.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset; assertion clears state immediately, release is synchronous to CLK.
REQ-005 EN  input  1  prescaler run enable; low freezes prescaler and counter.
REQ-006 DIV  input  PRE_W  divisor; one count step every DIV+1 enabled cycles.
REQ-007 MODE  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
REQ-008 LIMIT  input  WIDTH  inclusive top of count range [0..LIMIT].
REQ-009 LOAD  input  1  synchronous load strobe.
REQ-010 LOAD_VAL  input  WIDTH  value written to COUNT on LOAD.
REQ-011 COUNT  output  WIDTH  registered count value.
REQ-012 TICK  output  1  registered one-cycle pulse, high in the cycle the stepped COUNT is first visible.
REQ-013 WRAP  output  1  registered one-cycle pulse, high with TICK when the step hit a range boundary.
REQ-014 DIR  output  1  registered direction, 1 = up, 0 = down.

Function
REQ-015 Internal prescaler pre_cnt (PRE_W bits); step condition = EN high, LOAD low, pre_cnt >= DIV.
REQ-016 On step: pre_cnt <= 0, COUNT updates on the same edge, TICK = 1 next cycle; otherwise with EN high pre_cnt increments and TICK = 0.
REQ-017 DIV = 0 steps every enabled cycle; DIV lowered below pre_cnt steps on the next enabled edge (>= compare, no wrap-through).
REQ-018 EN low: pre_cnt, COUNT, DIR hold; TICK = WRAP = 0.
REQ-019 Up step: COUNT >= LIMIT -> COUNT <= 0, WRAP; else COUNT + 1; DIR <= 1.
REQ-020 Down step: COUNT == 0 or COUNT > LIMIT -> COUNT <= LIMIT, WRAP; else COUNT - 1; DIR <= 0.
REQ-021 Ping-pong step, DIR = 1: COUNT >= LIMIT -> DIR <= 0, COUNT <= LIMIT - 1 (0 if LIMIT == 0), WRAP; else COUNT + 1.
REQ-022 Ping-pong step, DIR = 0: COUNT == 0 -> DIR <= 1, COUNT <= 1 (0 if LIMIT == 0), WRAP; COUNT > LIMIT -> COUNT <= LIMIT, no WRAP; else COUNT - 1.
REQ-023 Hold step: COUNT, DIR unchanged; TICK still pulses; WRAP = 0.
REQ-024 LOAD high (any EN, any MODE): COUNT <= LOAD_VAL, pre_cnt <= 0, DIR <= 1 when MODE is up or ping-pong, 0 when down, unchanged when hold; TICK = WRAP = 0; LOAD has priority over step.
REQ-025 MODE, LIMIT, DIV changes take effect at the next step; no arithmetic overflow beyond WIDTH (all results are within 0..2^WIDTH-1).

Reset
REQ-026 RESET low: COUNT = 0, pre_cnt = 0, DIR = 1, TICK = 0, WRAP = 0, and, when built with capture, CAP_VAL = 0, CAP_VALID = 0, CAP_OVR = 0.
REQ-027 RESET asserted mid-step discards the step; first step after release needs DIV+1 enabled cycles.

Configuration
REQ-028 Macro PRESCALED_COUNTER_CAPTURE_EN defined: add ports CAPTURE input 1, CAP_ACK input 1, CAP_VAL output WIDTH, CAP_VALID output 1, CAP_OVR output 1.
REQ-029 With macro: CAPTURE high -> CAP_VAL <= COUNT (pre-edge value), CAP_VALID <= 1; CAP_ACK clears CAP_VALID and CAP_OVR; CAPTURE while CAP_VALID = 1 without CAP_ACK overwrites CAP_VAL and sets sticky CAP_OVR; CAPTURE and CAP_ACK in the same cycle -> CAP_VALID stays 1, CAP_OVR = 0.
REQ-030 Without macro: capture ports and logic absent; all other behaviour identical.

Verification
REQ-031 DIV = 3, MODE = up, LIMIT = 5, EN = 1 from reset -> TICK every 4th cycle; COUNT 1,2,3,4,5,0; WRAP with the 0.
REQ-032 DIV = 0, MODE = ping-pong, LIMIT = 3 -> COUNT 1,2,3,2,1,0,1; WRAP at 3 and at 0; DIR toggles on those edges.
REQ-033 MODE = down, COUNT = 0, LIMIT = 9, DIV = 0 -> COUNT 9, WRAP = 1; then LIMIT = 4 with COUNT = 9 -> COUNT 4, WRAP = 1.
REQ-034 LOAD = 1, LOAD_VAL = 7 coincident with a step -> COUNT = 7, TICK = 0, pre_cnt restarts; EN = 0 for 10 cycles -> COUNT stays 7.
REQ-035 RESET pulsed low mid-count with DIV = 2 -> COUNT = 0, DIR = 1 immediately; first TICK 3 enabled cycles after release.
REQ-036 Capture build: CAPTURE at COUNT = 4, again at COUNT = 6 without ack -> CAP_VAL = 6, CAP_OVR = 1; CAP_ACK -> CAP_VALID = 0, CAP_OVR = 0.

Source files
------------

// File: rtl/prescaled_counter.sv
// prescaled_counter: prescaled up / down / ping-pong / hold counter with
// a synchronous load, an inclusive range [0..limit], and registered
// step (tick) and boundary (wrap) pulses.
//
// Optional feature: define PRESCALED_COUNTER_CAPTURE_EN to add a capture
// register with valid / acknowledge / sticky overrun flags. Without the
// macro the capture ports and logic are absent.
//
// Handshake on the capture port: i_capture samples the pre-edge count into
// o_cap_val and raises o_cap_valid; i_cap_ack clears o_cap_valid and
// o_cap_ovr; a capture landing on an unacknowledged value overwrites it and
// sets o_cap_ovr; capture and ack in the same cycle leave valid high and
// overrun clear.
module prescaled_counter #(
    parameter int WIDTH = 32,
    parameter int PRE_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [PRE_W-1:0] i_div,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    input  logic             i_capture,
    input  logic             i_cap_ack,
    output logic [WIDTH-1:0] o_cap_val,
    output logic             o_cap_valid,
    output logic             o_cap_ovr,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_tick,
    output logic             o_wrap,
    output logic             o_dir
);

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    // State
    logic [PRE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_tick;
    logic             r_wrap;

    // Step qualification and the values the counter takes on a step
    logic             w_step;
    logic             w_at_top;
    logic             w_at_zero;
    logic             w_above;
    logic [WIDTH-1:0] w_limit_dec;
    logic [WIDTH-1:0] w_bounce_up;
    logic [WIDTH-1:0] w_count_inc;
    logic [WIDTH-1:0] w_count_dec;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_dir_nxt;
    logic             w_wrap_nxt;
    logic             w_load_dir;

    // A step needs the prescaler to have reached the divisor. The >= compare
    // means a divisor lowered below the running prescaler steps on the next
    // enabled edge instead of wrapping through the whole prescaler range.
    assign w_step    = i_en && !i_load && (r_pre_cnt >= i_div);

    assign w_at_top  = (r_count >= i_limit);
    assign w_at_zero = (r_count == '0);
    assign w_above   = (r_count > i_limit);

    // Increment is only selected when count < limit, decrement only when
    // count > 0, so neither can leave the WIDTH-bit range.
    assign w_count_inc = r_count + WIDTH'(1);
    assign w_count_dec = r_count - WIDTH'(1);

    // Ping-pong turnaround targets collapse to 0 for a degenerate range.
    assign w_limit_dec = (i_limit == '0) ? '0 : (i_limit - WIDTH'(1));
    assign w_bounce_up = (i_limit == '0) ? '0 : WIDTH'(1);

    // Next count / direction / wrap for a step in the current mode
    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_wrap_nxt  = 1'b0;
        case (i_mode)
            MODE_UP: begin
                w_dir_nxt = 1'b1;
                if (w_at_top) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = w_count_inc;
                end
            end
            MODE_DOWN: begin
                w_dir_nxt = 1'b0;
                if (w_at_zero || w_above) begin
                    w_count_nxt = i_limit;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = w_count_dec;
                end
            end
            MODE_PING: begin
                if (r_dir) begin
                    if (w_at_top) begin
                        w_dir_nxt   = 1'b0;
                        w_count_nxt = w_limit_dec;
                        w_wrap_nxt  = 1'b1;
                    end else begin
                        w_count_nxt = w_count_inc;
                    end
                end else begin
                    if (w_at_zero) begin
                        w_dir_nxt   = 1'b1;
                        w_count_nxt = w_bounce_up;
                        w_wrap_nxt  = 1'b1;
                    end else if (w_above) begin
                        // Range shrank under a descending count: clamp
                        // back into range without flagging a boundary.
                        w_count_nxt = i_limit;
                    end else begin
                        w_count_nxt = w_count_dec;
                    end
                end
            end
            MODE_HOLD: begin
                w_count_nxt = r_count;
                w_dir_nxt   = r_dir;
                w_wrap_nxt  = 1'b0;
            end
            default: begin
                w_count_nxt = r_count;
                w_dir_nxt   = r_dir;
                w_wrap_nxt  = 1'b0;
            end
        endcase
    end

    // Direction written by a load: up-like modes face up, down faces down,
    // hold keeps whatever direction it had.
    always_comb begin
        w_load_dir = r_dir;
        case (i_mode)
            MODE_UP:   w_load_dir = 1'b1;
            MODE_DOWN: w_load_dir = 1'b0;
            MODE_PING: w_load_dir = 1'b1;
            MODE_HOLD: w_load_dir = r_dir;
            default:   w_load_dir = r_dir;
        endcase
    end

    // Prescaler: restart on load or step, advance on other enabled cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre_cnt <= '0;
        end else if (i_load) begin
            r_pre_cnt <= '0;
        end else if (i_en) begin
            if (w_step) begin
                r_pre_cnt <= '0;
            end else begin
                // Only reached while r_pre_cnt < i_div, so no overflow.
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end
        end
    end

    // Counter, direction and the step/boundary pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_dir   <= 1'b1;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_dir   <= w_load_dir;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_step) begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_tick  <= 1'b1;
            r_wrap  <= w_wrap_nxt;
        end else begin
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign o_count = r_count;
    assign o_tick  = r_tick;
    assign o_wrap  = r_wrap;
    assign o_dir   = r_dir;

`ifdef PRESCALED_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] r_cap_val;
    logic             r_cap_valid;
    logic             r_cap_ovr;

    // Capture register with valid / ack handshake and sticky overrun
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cap_val   <= '0;
            r_cap_valid <= 1'b0;
            r_cap_ovr   <= 1'b0;
        end else if (i_capture) begin
            r_cap_val   <= r_count;
            r_cap_valid <= 1'b1;
            if (i_cap_ack) begin
                r_cap_ovr <= 1'b0;
            end else if (r_cap_valid) begin
                r_cap_ovr <= 1'b1;
            end
        end else if (i_cap_ack) begin
            r_cap_valid <= 1'b0;
            r_cap_ovr   <= 1'b0;
        end
    end

    assign o_cap_val   = r_cap_val;
    assign o_cap_valid = r_cap_valid;
    assign o_cap_ovr   = r_cap_ovr;
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter: directed scenarios plus a
// randomized run compared against a behavioural model of the counting rules.
module tb_prescaled_counter;
  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [PW-1:0] div;
  logic [1:0]    mode;
  logic [W-1:0]  limit;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic          tick;
  logic          wrap;
  logic          dir;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
  logic          capture;
  logic          cap_ack;
  logic [W-1:0]  cap_val;
  logic          cap_valid;
  logic          cap_ovr;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [W-1:0] m_count;
  int           m_pre;
  logic         m_dir;
  logic         m_tick;
  logic         m_wrap;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
  logic [W-1:0] m_cap_val;
  logic         m_cap_valid;
  logic         m_cap_ovr;
`endif

  prescaled_counter #(.WIDTH(W), .PRE_W(PW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_div      (div),
    .i_mode     (mode),
    .i_limit    (limit),
    .i_load     (load),
    .i_load_val (load_val),
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    .i_capture  (capture),
    .i_cap_ack  (cap_ack),
    .o_cap_val  (cap_val),
    .o_cap_valid(cap_valid),
    .o_cap_ovr  (cap_ovr),
`endif
    .o_count    (count),
    .o_tick     (tick),
    .o_wrap     (wrap),
    .o_dir      (dir)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic model_reset();
    m_count = '0;
    m_pre   = 0;
    m_dir   = 1'b1;
    m_tick  = 1'b0;
    m_wrap  = 1'b0;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    m_cap_val   = '0;
    m_cap_valid = 1'b0;
    m_cap_ovr   = 1'b0;
`endif
  endtask

  // One rising edge of the reference: counting rules in plain integers.
  task automatic model_edge();
    int c;
    int lim;
    c   = int'(m_count);
    lim = int'(limit);
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    if (capture) begin
      m_cap_ovr   = cap_ack ? 1'b0 : (m_cap_valid ? 1'b1 : m_cap_ovr);
      m_cap_val   = m_count;
      m_cap_valid = 1'b1;
    end else if (cap_ack) begin
      m_cap_valid = 1'b0;
      m_cap_ovr   = 1'b0;
    end
`endif
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (load) begin
      c     = int'(load_val);
      m_pre = 0;
      if (mode == 2'd0 || mode == 2'd2) m_dir = 1'b1;
      else if (mode == 2'd1)            m_dir = 1'b0;
    end else if (en) begin
      if (m_pre < int'(div)) begin
        m_pre = m_pre + 1;
      end else begin
        m_pre  = 0;
        m_tick = 1'b1;
        if (mode == 2'd0) begin
          m_dir = 1'b1;
          if (c >= lim) begin c = 0; m_wrap = 1'b1; end
          else c = c + 1;
        end else if (mode == 2'd1) begin
          m_dir = 1'b0;
          if (c == 0 || c > lim) begin c = lim; m_wrap = 1'b1; end
          else c = c - 1;
        end else if (mode == 2'd2) begin
          if (m_dir) begin
            if (c >= lim) begin
              m_dir = 1'b0; c = (lim == 0) ? 0 : lim - 1; m_wrap = 1'b1;
            end else c = c + 1;
          end else begin
            if (c == 0) begin
              m_dir = 1'b1; c = (lim == 0) ? 0 : 1; m_wrap = 1'b1;
            end else if (c > lim) c = lim;
            else c = c - 1;
          end
        end
      end
    end
    m_count = c[W-1:0];
  endtask

  // driver: advance one clock, update the model, settle for sampling
  task automatic tick_clk();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div = '0; mode = 2'd0; limit = '0;
    load = 1'b0; load_val = '0;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    capture = 1'b0; cap_ack = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_tests++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
    n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    n_tests++; if (dir !== 1'b1) begin n_fail++; $display("FAIL reset_dir got %b exp 1", dir); end
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    n_tests++; if (cap_valid !== 1'b0 || cap_ovr !== 1'b0 || cap_val !== 8'd0) begin
      n_fail++; $display("FAIL reset_cap got val=%0d v=%b o=%b exp 0/0/0", cap_val, cap_valid, cap_ovr);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    int exp_c[6] = '{1, 2, 3, 4, 5, 0};
    int n_tick;
    int last_cyc;
    div = 4'd3; mode = 2'd0; limit = 8'd5; en = 1'b1; load = 1'b0;
    do_reset();
    n_tick = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      tick_clk();
      if (tick === 1'b1) begin
        n_tests++;
        if (cyc - last_cyc !== 4) begin
          n_fail++; $display("FAIL up_tick_spacing got %0d exp 4", cyc - last_cyc);
        end
        last_cyc = cyc;
        if (n_tick < 6) begin
          n_tests++;
          if (int'(count) !== exp_c[n_tick]) begin
            n_fail++; $display("FAIL up_count got %0d exp %0d", count, exp_c[n_tick]);
          end
          n_tests++;
          if (wrap !== (exp_c[n_tick] == 0)) begin
            n_fail++; $display("FAIL up_wrap got %b at count %0d", wrap, count);
          end
        end
        n_tick++;
      end
    end
    n_tests++;
    if (n_tick !== 6) begin n_fail++; $display("FAIL up_tick_total got %0d exp 6", n_tick); end
  endtask

  task automatic test_pingpong();
    int   exp_c[7] = '{1, 2, 3, 2, 1, 0, 1};
    logic exp_w[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic exp_d[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    div = 4'd0; mode = 2'd2; limit = 8'd3; en = 1'b1; load = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick_clk();
      n_tests++;
      if (int'(count) !== exp_c[i] || wrap !== exp_w[i] || dir !== exp_d[i] || tick !== 1'b1) begin
        n_fail++;
        $display("FAIL pingpong_step%0d got c=%0d w=%b d=%b t=%b exp c=%0d w=%b d=%b t=1",
                 i, count, wrap, dir, tick, exp_c[i], exp_w[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_down();
    div = 4'd0; mode = 2'd1; limit = 8'd9; en = 1'b1;
    load = 1'b1; load_val = 8'd0;
    tick_clk();
    load = 1'b0;
    n_tests++;
    if (count !== 8'd0 || dir !== 1'b0 || tick !== 1'b0) begin
      n_fail++; $display("FAIL down_load got c=%0d d=%b t=%b exp 0/0/0", count, dir, tick);
    end
    tick_clk();
    n_tests++;
    if (count !== 8'd9 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL down_wrap_zero got c=%0d w=%b exp 9/1", count, wrap);
    end
    load = 1'b1; load_val = 8'd9; limit = 8'd4;
    tick_clk();
    load = 1'b0;
    tick_clk();
    n_tests++;
    if (count !== 8'd4 || wrap !== 1'b1) begin
      n_fail++; $display("FAIL down_clamp got c=%0d w=%b exp 4/1", count, wrap);
    end
    tick_clk();
    n_tests++;
    if (count !== 8'd3 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL down_dec got c=%0d w=%b exp 3/0", count, wrap);
    end
  endtask

  task automatic test_load_priority();
    int waited;
    div = 4'd3; mode = 2'd0; limit = 8'd20; en = 1'b1; load = 1'b0;
    do_reset();
    tick_clk();
    waited = 0;
    while (m_pre != 3 && waited < 10) begin tick_clk(); waited++; end
    n_tests++;
    if (m_pre != 3) begin n_fail++; $display("FAIL load_setup got pre=%0d exp 3", m_pre); end
    load = 1'b1; load_val = 8'd7;
    tick_clk();
    load = 1'b0;
    n_tests++;
    if (count !== 8'd7 || tick !== 1'b0 || wrap !== 1'b0) begin
      n_fail++; $display("FAIL load_over_step got c=%0d t=%b w=%b exp 7/0/0", count, tick, wrap);
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_clk();
      n_tests++;
      if (count !== 8'd7 || tick !== 1'b0) begin
        n_fail++; $display("FAIL load_freeze got c=%0d t=%b exp 7/0", count, tick);
      end
    end
    en = 1'b1;
    waited = 0;
    do begin tick_clk(); waited++; end while (tick !== 1'b1 && waited < 12);
    n_tests++;
    if (waited !== 4 || count !== 8'd8) begin
      n_fail++; $display("FAIL load_restart got %0d cycles c=%0d exp 4 cycles c=8", waited, count);
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    div = 4'd2; mode = 2'd1; limit = 8'd20; en = 1'b1; load = 1'b0;
    do_reset();
    for (int i = 0; i < 7; i++) tick_clk();
    n_tests++;
    if (count !== m_count || dir !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre got c=%0d d=%b exp %0d/0", count, dir, m_count);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (count !== 8'd0 || dir !== 1'b1 || tick !== 1'b0) begin
      n_fail++; $display("FAIL mid_async got c=%0d d=%b t=%b exp 0/1/0", count, dir, tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waited = 0;
    do begin tick_clk(); waited++; end while (tick !== 1'b1 && waited < 10);
    n_tests++;
    if (waited !== 3 || count !== 8'd20) begin
      n_fail++; $display("FAIL mid_first_tick got %0d cycles c=%0d exp 3 cycles c=20", waited, count);
    end
  endtask

`ifdef PRESCALED_COUNTER_CAPTURE_EN
  task automatic test_capture();
    int waited;
    div = 4'd0; mode = 2'd0; limit = 8'd20; en = 1'b1; load = 1'b0;
    capture = 1'b0; cap_ack = 1'b0;
    do_reset();
    waited = 0;
    while (m_count != 8'd4 && waited < 20) begin tick_clk(); waited++; end
    capture = 1'b1;
    tick_clk();
    capture = 1'b0;
    n_tests++;
    if (cap_val !== 8'd4 || cap_valid !== 1'b1 || cap_ovr !== 1'b0) begin
      n_fail++; $display("FAIL cap_first got v=%0d vl=%b o=%b exp 4/1/0", cap_val, cap_valid, cap_ovr);
    end
    while (m_count != 8'd6 && waited < 40) begin tick_clk(); waited++; end
    capture = 1'b1;
    tick_clk();
    capture = 1'b0;
    n_tests++;
    if (cap_val !== 8'd6 || cap_valid !== 1'b1 || cap_ovr !== 1'b1) begin
      n_fail++; $display("FAIL cap_overrun got v=%0d vl=%b o=%b exp 6/1/1", cap_val, cap_valid, cap_ovr);
    end
    cap_ack = 1'b1;
    tick_clk();
    cap_ack = 1'b0;
    n_tests++;
    if (cap_valid !== 1'b0 || cap_ovr !== 1'b0) begin
      n_fail++; $display("FAIL cap_ack got vl=%b o=%b exp 0/0", cap_valid, cap_ovr);
    end
    capture = 1'b1;
    tick_clk();
    cap_ack = 1'b1;
    tick_clk();
    capture = 1'b0; cap_ack = 1'b0;
    n_tests++;
    if (cap_valid !== 1'b1 || cap_ovr !== 1'b0 || cap_val !== m_cap_val) begin
      n_fail++; $display("FAIL cap_same_cycle got v=%0d vl=%b o=%b exp %0d/1/0", cap_val, cap_valid, cap_ovr, m_cap_val);
    end
  endtask
`endif

  task automatic test_random();
    div = 4'd1; mode = 2'd0; limit = 8'd10; en = 1'b1; load = 1'b0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) div = 4'($urandom_range(0, 4));
      if ($urandom_range(0, 39) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 12));
      en       = ($urandom_range(0, 7) != 0);
      load     = ($urandom_range(0, 24) == 0);
      load_val = 8'($urandom_range(0, 255));
`ifdef PRESCALED_COUNTER_CAPTURE_EN
      capture  = ($urandom_range(0, 5) == 0);
      cap_ack  = ($urandom_range(0, 5) == 0);
`endif
      tick_clk();
      n_tests++;
      if (count !== m_count || tick !== m_tick || wrap !== m_wrap || dir !== m_dir) begin
        n_fail++;
        $display("FAIL random_cyc%0d got c=%0d t=%b w=%b d=%b exp c=%0d t=%b w=%b d=%b",
                 i, count, tick, wrap, dir, m_count, m_tick, m_wrap, m_dir);
      end
`ifdef PRESCALED_COUNTER_CAPTURE_EN
      n_tests++;
      if (cap_val !== m_cap_val || cap_valid !== m_cap_valid || cap_ovr !== m_cap_ovr) begin
        n_fail++;
        $display("FAIL random_cap_cyc%0d got %0d/%b/%b exp %0d/%b/%b",
                 i, cap_val, cap_valid, cap_ovr, m_cap_val, m_cap_valid, m_cap_ovr);
      end
`endif
    end
    load = 1'b0;
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    capture = 1'b0; cap_ack = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_pingpong();
    test_down();
    test_load_priority();
    test_reset_mid();
`ifdef PRESCALED_COUNTER_CAPTURE_EN
    test_capture();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
